// File: rtl/servo_pulse_decoder_if.sv
// Signal bundle between an RC-servo PWM source and the pulse decoder.
// master = PWM source / consumer side, slave = decoder.
interface servo_pulse_decoder_if;
    logic       pwm_in;
    logic [7:0] position;
    logic       valid;
    logic       sample_stb;
    logic       err_short;
    logic       err_long;
    logic       timeout;

    modport master (
        output pwm_in,
        input  position, valid, sample_stb, err_short, err_long, timeout
    );

    modport slave (
        input  pwm_in,
        output position, valid, sample_stb, err_short, err_long, timeout
    );
endinterface

// File: rtl/servo_pulse_decoder.sv
// Measures RC-servo PWM high time and converts it to an 8-bit position code,
// flagging short/long pulses and loss of signal. Division-free quotient.
module servo_pulse_decoder #(
    parameter int unsigned SHORT_TICKS   = 5000,
    parameter int unsigned MIN_TICKS     = 10000,
    parameter int unsigned STEP_TICKS    = 39,
    parameter int unsigned MAX_TICKS     = 25000,
    parameter int unsigned TIMEOUT_TICKS = 500000
) (
    input  logic                  clk,
    input  logic                  reset,
    servo_pulse_decoder_if.slave  bus
);
    localparam int unsigned CW = 21;

    localparam logic [CW-1:0] ONE_W     = CW'(1);
    localparam logic [CW-1:0] SHORT_W   = CW'(SHORT_TICKS);
    localparam logic [CW-1:0] MIN_W     = CW'(MIN_TICKS);
    localparam logic [CW-1:0] STEP_LAST = CW'(STEP_TICKS - 1);
    localparam logic [CW-1:0] MAX_W     = CW'(MAX_TICKS);
    localparam logic [CW-1:0] SAT_W     = CW'(MAX_TICKS + 1);
    localparam logic [CW-1:0] TIMEOUT_W = CW'(TIMEOUT_TICKS);

    typedef enum logic {S_IDLE, S_HIGH} state_t;

    state_t        state_q, state_d;
    logic          pwm_m, pwm_s, pwm_d;
    logic          rise_c, fall_c;
    logic [CW-1:0] w_q, w_d;
    logic [CW-1:0] t_q, t_d;
    logic [CW-1:0] sub_q, sub_d;
    logic [7:0]    acc_q, acc_d;
    logic [7:0]    position_q, position_d;
    logic          valid_q, valid_d;
    logic          stb_q, stb_d;
    logic          err_short_q, err_short_d;
    logic          err_long_q, err_long_d;
    logic          timeout_q, timeout_d;

    // Synchroniser and edge-delay flops idle high so a pulse in progress at
    // reset release produces no rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_m <= 1'b1;
            pwm_s <= 1'b1;
            pwm_d <= 1'b1;
        end else begin
            pwm_m <= bus.pwm_in;
            pwm_s <= pwm_m;
            pwm_d <= pwm_s;
        end
    end

    assign rise_c = pwm_s & ~pwm_d;
    assign fall_c = ~pwm_s & pwm_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            w_q         <= '0;
            t_q         <= '0;
            sub_q       <= '0;
            acc_q       <= '0;
            position_q  <= '0;
            valid_q     <= 1'b0;
            stb_q       <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            t_q         <= t_d;
            sub_q       <= sub_d;
            acc_q       <= acc_d;
            position_q  <= position_d;
            valid_q     <= valid_d;
            stb_q       <= stb_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        t_d         = t_q;
        sub_d       = sub_q;
        acc_d       = acc_q;
        position_d  = position_q;
        valid_d     = valid_q;
        stb_d       = 1'b0;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        timeout_d   = timeout_q;

        // Loss-of-signal counter: a rise always wins over reaching the limit.
        if (rise_c) begin
            t_d = '0;
        end else if (t_q != TIMEOUT_W) begin
            t_d = t_q + ONE_W;
            if (t_d == TIMEOUT_W) begin
                timeout_d = 1'b1;
                valid_d   = 1'b0;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (rise_c) begin
                    state_d = S_HIGH;
                    w_d     = ONE_W;
                    sub_d   = '0;
                    acc_d   = '0;
                end
            end
            S_HIGH: begin
                if (fall_c) begin
                    state_d = S_IDLE;
                    w_d     = '0;
                    if (w_q < SHORT_W) begin
                        err_short_d = 1'b1;
                    end else if (w_q > MAX_W) begin
                        err_long_d = 1'b1;
                    end else begin
                        position_d = acc_q;
                        valid_d    = 1'b1;
                        timeout_d  = 1'b0;
                        stb_d      = 1'b1;
                    end
                end else if (pwm_s && (w_q != SAT_W)) begin
                    w_d = w_q + ONE_W;
                    // acc/sub track floor/mod of (W - MIN) / STEP as W grows
                    if (w_q >= MIN_W) begin
                        if (sub_q == STEP_LAST) begin
                            sub_d = '0;
                            if (acc_q != 8'hFF) acc_d = acc_q + 8'd1;
                        end else begin
                            sub_d = sub_q + ONE_W;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.position   = position_q;
    assign bus.valid      = valid_q;
    assign bus.sample_stb = stb_q;
    assign bus.err_short  = err_short_q;
    assign bus.err_long   = err_long_q;
    assign bus.timeout    = timeout_q;
endmodule

// File: doc/servo_pulse_decoder.md
# servo_pulse_decoder

Measures the high time of an incoming RC-servo PWM signal (nominal 1–2 ms pulse, 20 ms frame) and converts it to an 8-bit position code. It is the receiving counterpart of the servo tester's PWM generator and shares its clocking assumptions (10 MHz clock, 8-bit position scale). The decoder also flags malformed pulses and signal loss, so it can be used to loop-test the generator or to read an external RC receiver.

## Interface
Parameters:
- `SHORT_TICKS`, default 5000: minimum legal pulse width in clocks (0.5 ms).
- `MIN_TICKS`, default 10000: pulse width that maps to position 0 (1 ms).
- `STEP_TICKS`, default 39: clocks per position LSB above `MIN_TICKS`.
- `MAX_TICKS`, default 25000: maximum legal pulse width in clocks (2.5 ms).
- `TIMEOUT_TICKS`, default 500000: clocks without a rising edge before signal loss (50 ms).
- Required: `1 <= SHORT_TICKS <= MIN_TICKS < MAX_TICKS < TIMEOUT_TICKS < 2^21`, `STEP_TICKS >= 1`.

Ports:
- `clk`, input, 1 bit: single clock for all logic.
- `reset`, input, 1 bit: asynchronous, active-high reset.
- `pwm_in`, input, 1 bit: servo PWM input, asynchronous to `clk`.
- `position`, output, 8 bits: last accepted position code.
- `valid`, output, 1 bit: high while `position` holds a live measurement.
- `sample_stb`, output, 1 bit: one-cycle pulse when `position` updates.
- `err_short`, output, 1 bit: one-cycle pulse on a rejected short pulse.
- `err_long`, output, 1 bit: one-cycle pulse on a rejected long pulse.
- `timeout`, output, 1 bit: level, signal lost.

## Operation
- **Synchroniser.** `pwm_in` passes through a 2-flop synchroniser to give `pwm_s`, plus one delay flop `pwm_d` for edge detection.
  - All three flops reset to 1. A pulse already in progress at reset release is therefore never measured, and no false rising edge is generated.
- **Edge definitions.** rise = `pwm_s & ~pwm_d`; fall = `~pwm_s & pwm_d`.
- **State machine.**
  - IDLE: wait for rise. On rise, go to HIGH with the width counter W = 1.
  - HIGH: W increments each cycle `pwm_s` = 1. W saturates at `MAX_TICKS+1`, so 21-bit counters are sufficient. On fall, evaluate W and return to IDLE.
- **Evaluation at fall.** W is the number of cycles `pwm_s` was high.
  - W < `SHORT_TICKS`: `err_short` pulses; `position` and `valid` are unchanged.
  - W > `MAX_TICKS`: `err_long` pulses; `position` and `valid` are unchanged.
  - Otherwise the pulse is accepted: `position` = 0 if W <= `MIN_TICKS`, else min(255, floor((W−`MIN_TICKS`)/`STEP_TICKS`)). `valid` ← 1, `timeout` ← 0, and `sample_stb` pulses.
  - Boundaries: W = `SHORT_TICKS` and W = `MAX_TICKS` are both accepted.
- **No divider.** The quotient is formed with a step sub-counter (0..`STEP_TICKS`−1) running while W > `MIN_TICKS`. It increments a saturating 8-bit position accumulator.
- **Timeout.** A free counter T is cleared on every rise and increments otherwise, in any state. When T reaches `TIMEOUT_TICKS`: `valid` ← 0, `timeout` ← 1, and T holds.
  - A stuck-high input produces no rise, so it ends in timeout. Any pending HIGH measurement continues, and a later fall is still evaluated.
  - If rise and T = `TIMEOUT_TICKS` occur in the same cycle, the rise wins: T is cleared and `timeout` is not set.
- **Reset mid-pulse.** All state returns to IDLE and all outputs go to 0 immediately.

## Timing
- Reset values: `position` = 0, `valid` = 0, `sample_stb` = 0, `err_short` = 0, `err_long` = 0, `timeout` = 0; FSM in IDLE; W = 0; T = 0.
- All outputs are registered.
- Latency: let `pwm_in` be sampled low at edge N.
  - `pwm_s` goes low at edge N+1.
  - `position`, `valid`, `sample_stb` and the error strobes update at edge N+2.
- The synchroniser delays both edges equally, so W equals the pulse width in sampled clocks (±1 for asynchronous edge alignment).
- Strobes last exactly one cycle. At most one of `sample_stb`, `err_short` or `err_long` fires per pulse.
- `timeout` rises at the edge where T reaches `TIMEOUT_TICKS`. It clears on the same edge that asserts `sample_stb`.

## Test plan
All scenarios use default parameters, a 10 MHz clock, and 20 ms frames unless stated.
- **Reset during pulse.** Assert `reset` mid-pulse, release while `pwm_in` is high → no strobe for that pulse, all outputs 0. The next full 15000-clock pulse → `position` = 128, `valid` = 1.
- **In-range widths.** Pulses of 10000, 15000 and 20000 clocks → `position` 0, 128 and 255 (clamped) respectively. Each gives one `sample_stb` cycle, 2 edges after the fall is sampled.
- **Boundary widths.** Pulses of 10038 and 10039 clocks → `position` 0 and 1. Pulses of 5000 and 25000 clocks → both accepted.
- **Rejected widths.** A 4999-clock pulse → `err_short` for one cycle, `position` unchanged. A 25001-clock pulse → `err_long` for one cycle, `position` unchanged.
- **Signal loss.** After a valid pulse, hold `pwm_in` low for 500000 clocks from the last rise → `valid` = 0, `timeout` = 1. The next 15000-clock pulse → `timeout` = 0, `valid` = 1, `position` = 128.
- **Stuck high.** Hold `pwm_in` high for 600000 clocks → `timeout` = 1. Then drop `pwm_in` → `err_long` pulses once.
